// File: rtl/product_accumulator_if.sv
// Product-in / sum-out handshake bundle for product_accumulator.
// The upstream producer and result consumer sit on the master side; the accumulator is the slave.
interface product_accumulator_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 3
);
    logic             prod_valid;
    logic [15:0]      prod_in;
    logic             prod_ready;
    logic             clear;
    logic             sum_valid;
    logic             sum_ready;
    logic [ACC_W-1:0] sum_out;
    logic             sum_ovf;
    logic [CNT_W-1:0] term_cnt;

    modport master (
        output prod_valid, prod_in, clear, sum_ready,
        input  prod_ready, sum_valid, sum_out, sum_ovf, term_cnt
    );

    modport slave (
        input  prod_valid, prod_in, clear, sum_ready,
        output prod_ready, sum_valid, sum_out, sum_ovf, term_cnt
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums groups of N_TERMS unsigned 16-bit products into a saturating ACC_W accumulator
// and hands each group result out on a valid/ready port.
module product_accumulator #(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    product_accumulator_if.slave  bus
);
    localparam int                CNT_W    = $clog2(N_TERMS);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_TERMS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_out_q, sum_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grp_ovf_q, grp_ovf_d;
    logic             sum_ovf_q, sum_ovf_d;

    logic             prod_ready;
    logic             sum_valid;
    logic             accept;
    logic             last_term;
    logic             ovf_now;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_sat;

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && last_term) state_d = HOLD;
            HOLD:    if (bus.sum_ready)       state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Ready looks only at state and clear, never at prod_valid or sum_ready.
    always_comb begin
        prod_ready = (state_q == ACCUM) && !bus.clear;
        sum_valid  = (state_q == HOLD);
    end

    assign accept    = bus.prod_valid && prod_ready;
    assign last_term = (cnt_q == LAST_CNT);
    assign sum_ext   = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, bus.prod_in};
    assign ovf_now   = sum_ext[ACC_W];
    assign acc_sat   = ovf_now ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

    always_comb begin
        // NOTE: every next-state value defaults to its current value so no latch is inferred.
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        grp_ovf_d = grp_ovf_q;
        sum_out_d = sum_out_q;
        sum_ovf_d = sum_ovf_q;
        if ((state_q == ACCUM) && bus.clear) begin
            acc_d     = '0;
            cnt_d     = '0;
            grp_ovf_d = 1'b0;
        end else if (accept) begin
            if (last_term) begin
                sum_out_d = acc_sat;
                sum_ovf_d = grp_ovf_q | ovf_now;
                acc_d     = '0;
                cnt_d     = '0;
                grp_ovf_d = 1'b0;
            end else begin
                acc_d     = acc_sat;
                cnt_d     = cnt_q + CNT_W'(1);
                grp_ovf_d = grp_ovf_q | ovf_now;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            grp_ovf_q <= 1'b0;
            sum_out_q <= '0;
            sum_ovf_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            grp_ovf_q <= grp_ovf_d;
            sum_out_q <= sum_out_d;
            sum_ovf_q <= sum_ovf_d;
        end
    end

    assign bus.prod_ready = prod_ready;
    assign bus.sum_valid  = sum_valid;
    assign bus.sum_out    = sum_out_q;
    assign bus.sum_ovf    = sum_ovf_q;
    assign bus.term_cnt   = cnt_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two configurations (8 terms/24 bits, 4 terms/17 bits)
// driven by directed scenarios then random traffic, checked against a group-list model.
module tb_product_accumulator;
    localparam int N_A = 8;
    localparam int W_A = 24;
    localparam int N_B = 4;
    localparam int W_B = 17;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    product_accumulator_if #(.ACC_W(W_A), .CNT_W($clog2(N_A))) if_a ();
    product_accumulator_if #(.ACC_W(W_B), .CNT_W($clog2(N_B))) if_b ();

    product_accumulator #(.N_TERMS(N_A), .ACC_W(W_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    product_accumulator #(.N_TERMS(N_B), .ACC_W(W_B)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    // Stimulus per DUT (index 0 = dut_a, 1 = dut_b)
    bit          v_in [2];
    logic [15:0] p_in [2];
    bit          c_in [2];
    bit          r_in [2];

    // Reference model: products of the open group are kept as a list and summed on completion
    int              n_terms [2];
    int              acc_w   [2];
    longint unsigned grp     [2][256];
    int              grp_n   [2];
    bit              hold    [2];
    longint unsigned exp_sum [2];
    bit              exp_ovf [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            grp_n[d]   = 0;
            hold[d]    = 1'b0;
            exp_sum[d] = 0;
            exp_ovf[d] = 1'b0;
        end
    endfunction

    function automatic void close_group(input int d);
        longint unsigned max_v = (64'd1 << acc_w[d]) - 1;
        longint unsigned s     = 0;
        bit              o     = 1'b0;
        for (int i = 0; i < grp_n[d]; i++) begin
            s = s + grp[d][i];
            if (s > max_v) begin
                s = max_v;
                o = 1'b1;
            end
        end
        exp_sum[d] = s;
        exp_ovf[d] = o;
    endfunction

    function automatic void model_step(input int d);
        if (!rst_n) begin
            grp_n[d]   = 0;
            hold[d]    = 1'b0;
            exp_sum[d] = 0;
            exp_ovf[d] = 1'b0;
        end else if (!hold[d]) begin
            if (c_in[d]) begin
                grp_n[d] = 0;
            end else if (v_in[d]) begin
                grp[d][grp_n[d]] = p_in[d];
                grp_n[d]++;
                if (grp_n[d] == n_terms[d]) begin
                    close_group(d);
                    hold[d]  = 1'b1;
                    grp_n[d] = 0;
                end
            end
        end else if (r_in[d]) begin
            hold[d] = 1'b0;
        end
    endfunction

    task automatic apply_inputs();
        if_a.prod_valid = v_in[0];
        if_a.prod_in    = p_in[0];
        if_a.clear      = c_in[0];
        if_a.sum_ready  = r_in[0];
        if_b.prod_valid = v_in[1];
        if_b.prod_in    = p_in[1];
        if_b.clear      = c_in[1];
        if_b.sum_ready  = r_in[1];
    endtask

    task automatic check_ready();
        check("a.prod_ready", if_a.prod_ready, 64'(!hold[0] && !c_in[0]));
        check("b.prod_ready", if_b.prod_ready, 64'(!hold[1] && !c_in[1]));
    endtask

    task automatic check_regs();
        check("a.sum_valid", if_a.sum_valid, 64'(hold[0]));
        check("a.term_cnt",  if_a.term_cnt,  64'(grp_n[0]));
        check("a.sum_out",   if_a.sum_out,   exp_sum[0]);
        check("a.sum_ovf",   if_a.sum_ovf,   64'(exp_ovf[0]));
        check("b.sum_valid", if_b.sum_valid, 64'(hold[1]));
        check("b.term_cnt",  if_b.term_cnt,  64'(grp_n[1]));
        check("b.sum_out",   if_b.sum_out,   exp_sum[1]);
        check("b.sum_ovf",   if_b.sum_ovf,   64'(exp_ovf[1]));
    endtask

    // One clock: drive, check the combinational ready, advance model and DUT, check registers
    task automatic tick();
        apply_inputs();
        #1;
        check_ready();
        for (int d = 0; d < 2; d++) model_step(d);
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic feed(input int d, input logic [15:0] val);
        v_in[d] = 1'b1;
        p_in[d] = val;
        tick();
        v_in[d] = 1'b0;
    endtask

    longint unsigned held;

    initial begin
        n_terms = '{N_A, N_B};
        acc_w   = '{W_A, W_B};
        for (int d = 0; d < 2; d++) begin
            v_in[d] = 1'b0;
            p_in[d] = '0;
            c_in[d] = 1'b0;
            r_in[d] = 1'b1;
        end
        apply_inputs();

        // Reset defaults
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        #1;
        check("rst.sum_valid",  if_a.sum_valid,  0);
        check("rst.sum_out",    if_a.sum_out,    0);
        check("rst.sum_ovf",    if_a.sum_ovf,    0);
        check("rst.term_cnt",   if_a.term_cnt,   0);
        check("rst.prod_ready", if_a.prod_ready, 1);

        // Group sum 1..8, back-to-back, sum_ready high
        for (int i = 1; i <= 8; i++) feed(0, 16'(i));
        check("grp.sum_out",   if_a.sum_out,    36);
        check("grp.sum_ovf",   if_a.sum_ovf,    0);
        check("grp.sum_valid", if_a.sum_valid,  1);
        check("grp.bubble",    if_a.prod_ready, 0);
        tick();
        check("grp.drop",      if_a.sum_valid,  0);
        check("grp.ready",     if_a.prod_ready, 1);

        // Full-scale sum without overflow
        for (int i = 0; i < 8; i++) feed(0, 16'hFFFF);
        check("full.sum_out", if_a.sum_out, 64'h07FFF8);
        check("full.sum_ovf", if_a.sum_ovf, 0);
        tick();

        // Saturation on the narrow configuration, then a clean group
        for (int i = 0; i < 4; i++) feed(1, 16'hFFFF);
        check("sat.sum_out", if_b.sum_out, 64'h1FFFF);
        check("sat.sum_ovf", if_b.sum_ovf, 1);
        tick();
        for (int i = 0; i < 4; i++) feed(1, 16'd1);
        check("sat.next_sum", if_b.sum_out, 4);
        check("sat.next_ovf", if_b.sum_ovf, 0);
        tick();

        // Backpressure: result held, clear and offered products ignored
        r_in[0] = 1'b0;
        for (int i = 0; i < 8; i++) feed(0, 16'($urandom_range(0, 16'hFFFF)));
        held = exp_sum[0];
        for (int i = 0; i < 5; i++) begin
            c_in[0] = 1'b1;
            v_in[0] = 1'b1;
            p_in[0] = 16'($urandom_range(0, 16'hFFFF));
            tick();
            check("bp.stable", if_a.sum_out,    held);
            check("bp.ready",  if_a.prod_ready, 0);
            check("bp.valid",  if_a.sum_valid,  1);
        end
        c_in[0] = 1'b0;
        v_in[0] = 1'b0;
        r_in[0] = 1'b1;
        tick();

        // Clear wins over an offered 4th product
        for (int i = 0; i < 3; i++) feed(0, 16'd5);
        c_in[0] = 1'b1;
        feed(0, 16'd7);
        c_in[0] = 1'b0;
        check("clr.term_cnt", if_a.term_cnt, 0);
        for (int i = 0; i < 8; i++) feed(0, 16'd2);
        check("clr.sum_out", if_a.sum_out, 16);
        tick();

        // Reset mid-group
        for (int i = 0; i < 5; i++) feed(0, 16'd3);
        check("mid.term_cnt_pre", if_a.term_cnt, 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid.term_cnt", if_a.term_cnt, 0);
        check("mid.sum_out",  if_a.sum_out,  0);
        for (int i = 0; i < 8; i++) feed(0, 16'd1);
        check("mid.sum", if_a.sum_out, 8);
        tick();

        // Random traffic on both configurations
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 2; d++) begin
                v_in[d] = ($urandom_range(0, 3) != 0);
                p_in[d] = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(16'hF000, 16'hFFFF))
                                                      : 16'($urandom_range(0, 16'h00FF));
                c_in[d] = ($urandom_range(0, 15) == 0);
                r_in[d] = ($urandom_range(0, 2) != 0);
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            v_in[d] = 1'b0;
            c_in[d] = 1'b0;
            r_in[d] = 1'b1;
        end
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the registered 8x8 multiplier's 16-bit product stream. It sums a fixed-length group of N_TERMS unsigned products into a wider accumulator, as a dot-product or MAC back end. Each completed sum is presented on a valid/ready output port. Overflow saturates and raises a sticky per-group flag.

## Interface
- N_TERMS, 8: products per group; legal range 2..256.
- ACC_W, 24: accumulator/result width; legal range 16..32.
- CNT_W, $clog2(N_TERMS): width of term_cnt, derived.
- clk, in, 1: single clock; all logic on its rising edge.
- rst_n, in, 1: synchronous, active-low reset, sampled on rising clk.
- prod_valid, in, 1: prod_in holds a product to consume.
- prod_in, in, 16: unsigned product.
- prod_ready, out, 1: block accepts prod_in this cycle.
- clear, in, 1: synchronous flush of a partial group.
- sum_valid, out, 1: sum_out/sum_ovf hold a completed group result.
- sum_ready, in, 1: consumer takes the result.
- sum_out, out, ACC_W: group sum, saturated.
- sum_ovf, out, 1: group saturated at least once.
- term_cnt, out, CNT_W: products accepted in the current group.

## Operation
- States: ACCUM, HOLD. Reset state is ACCUM.
- Reset values: acc=0, term_cnt=0, sum_out=0, sum_ovf=0, sum_valid=0. prod_ready is 1 after reset deasserts.
- prod_ready = (state==ACCUM) && !clear. It is combinational, with no dependency on prod_valid.
- Accept = prod_valid && prod_ready. On accept:
  - next = acc + zero-extended prod_in, computed at ACC_W+1 bits.
  - If next exceeds 2^ACC_W-1, acc loads all-ones and the group overflow flag sets.
  - Otherwise acc loads next.
- The overflow flag is sticky for the rest of the group.
- Accept with term_cnt < N_TERMS-1: term_cnt increments; state stays ACCUM.
- Accept with term_cnt == N_TERMS-1 (final term):
  - sum_out loads the saturated next value.
  - sum_ovf loads group flag OR overflow on this term.
  - sum_valid goes to 1.
  - acc, term_cnt and the group flag clear to 0.
  - State goes to HOLD.
- HOLD: prod_ready=0, and sum_out/sum_ovf stay stable. On sum_valid && sum_ready, sum_valid drops to 0 and the state returns to ACCUM.
- clear in ACCUM: acc, term_cnt and the group flag go to 0. Any product offered that cycle is not accepted, because prod_ready is low. clear wins over a final-term accept.
- clear in HOLD: ignored. A pending result is never dropped.
- Reset mid-group or in HOLD: all state returns to reset values, and the pending result is lost.
- Products with prod_valid=0 or prod_ready=0 have no effect. The upstream must hold prod_in until accepted.

## Timing
- Final term accepted at edge k: sum_valid=1 and sum_out valid after edge k. This is one cycle of latency from the accepting edge.
- Result accepted at edge m (sum_valid && sum_ready): prod_ready=1 in the cycle after edge m. There is a minimum one-cycle bubble between groups when sum_ready is held high.
- Throughput: N_TERMS products per N_TERMS+1 cycles with sum_ready tied high.
- term_cnt updates on the accepting edge and wraps N_TERMS-1 to 0 on the final term.
- No combinational path from sum_ready or prod_valid to any output. prod_ready depends only on state and clear.

## Test plan
- Reset, then defaults with N_TERMS=8, ACC_W=24: after rst_n low for 2 cycles, check sum_valid=0, sum_out=0, sum_ovf=0, term_cnt=0, prod_ready=1.
- Group sum: feed products 1..8 back-to-back with sum_ready=1. Expect sum_out=36, sum_ovf=0, and sum_valid high exactly one cycle after the 8th accept. prod_ready must be 0 for one cycle.
- Full-scale sum: feed 8 products of 0xFFFF. Expect sum_out=0x07FFF8 and sum_ovf=0.
- Saturation with N_TERMS=4, ACC_W=17: feed 0xFFFF x4. Expect sum_out=0x1FFFF and sum_ovf=1. The next group of 1,1,1,1 must give 4 with sum_ovf=0.
- Backpressure plus clear:
  - Hold sum_ready=0 for 5 cycles after a result. Expect prod_ready=0, sum_out stable, and clear ignored.
  - Release sum_ready. Feed 3 products, assert clear together with a 4th. Expect term_cnt=0 and the 4th product not accepted.
  - Feed 8 products of 2. Expect sum_out=16.
- Reset mid-group: after 5 accepts, pulse rst_n low for one cycle. Expect term_cnt=0, and the next 8 products of 1 sum to 8.
